// File: rtl/stopwatch_display.sv
// Four-digit common-anode seven-segment driver for the stopwatch digits.
// Ports: clk, reset (sync, active-high), four BCD digit inputs,
//   Blank/Blink_En controls, an[3:0] (active-low, an[0] = tenths),
//   seg[6:0] = {g,f,e,d,c,b,a} active-low, dp active-low.
module stopwatch_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_SCANS = 64,
    parameter bit LZB         = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Minutes,
    input  logic [3:0] Tens_Seconds,
    input  logic [3:0] Ones_Seconds,
    input  logic [3:0] Tenths_Seconds,
    input  logic       Blank,
    input  logic       Blink_En,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_SCANS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          tick;
    logic          scan_end;
    logic [3:0]    sel_digit;
    logic          suppress;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_comb begin
        presc_d     = presc_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        sel_digit   = 4'd0;

        tick     = (presc_q == PRESC_MAX);
        scan_end = tick && (idx_q == 2'd3);

        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
            idx_d = idx_q + 2'd1;
        end

        // All four digits are latched together at the end of a scan so
        // one scan never mixes old and new values.
        if (scan_end) begin
            snap_d = {Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds};
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        case (idx_q)
            2'd0:    sel_digit = snap_q[3:0];
            2'd1:    sel_digit = snap_q[7:4];
            2'd2:    sel_digit = snap_q[11:8];
            default: sel_digit = snap_q[15:12];
        endcase

        an_d  = ~(4'b0001 << idx_q);
        seg_d = seg_decode(sel_digit);
        dp_d  = (idx_q != 2'd1);

        // Every suppression source yields the same all-off pattern.
        suppress = Blank
                || (Blink_En && phase_q)
                || (LZB && (idx_q == 2'd3) && (snap_q[15:12] == 4'd0));
        if (suppress) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= '0;
            idx_q       <= 2'd0;
            snap_q      <= 16'd0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            an_q        <= 4'b1111;
            seg_q       <= 7'b1111111;
            dp_q        <= 1'b1;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display (REFRESH_DIV=4, BLINK_SCANS=2).
// Drives both an LZB=1 and an LZB=0 instance from the same stimulus.
module tb_stopwatch_display;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SD = 7'b0111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] minutes, tens_s, ones_s, tenths_s;
    logic       blank, blink_en;
    logic [3:0] an, an0;
    logic [6:0] seg, seg0;
    logic       dp, dp0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       blank;
        logic       blink;
        logic [3:0] m, t, o, th;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an0;
        logic [6:0] seg0;
        logic       dp0;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    stopwatch_display #(.REFRESH_DIV(4), .BLINK_SCANS(2), .LZB(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .Minutes(minutes), .Tens_Seconds(tens_s),
        .Ones_Seconds(ones_s), .Tenths_Seconds(tenths_s),
        .Blank(blank), .Blink_En(blink_en),
        .an(an), .seg(seg), .dp(dp)
    );

    stopwatch_display #(.REFRESH_DIV(4), .BLINK_SCANS(2), .LZB(1'b0)) u_dut0 (
        .clk(clk), .reset(reset),
        .Minutes(minutes), .Tens_Seconds(tens_s),
        .Ones_Seconds(ones_s), .Tenths_Seconds(tenths_s),
        .Blank(blank), .Blink_En(blink_en),
        .an(an0), .seg(seg0), .dp(dp0)
    );

    task automatic add2(input logic bl, input logic bk,
                        input logic [3:0] m, input logic [3:0] t,
                        input logic [3:0] o, input logic [3:0] th,
                        input logic [3:0] ea, input logic [6:0] es,
                        input logic ed, input logic [3:0] ea0,
                        input logic [6:0] es0, input logic ed0);
        vec_t v;
        v.blank = bl; v.blink = bk;
        v.m = m; v.t = t; v.o = o; v.th = th;
        v.an = ea; v.seg = es; v.dp = ed;
        v.an0 = ea0; v.seg0 = es0; v.dp0 = ed0;
        vecs.push_back(v);
    endtask

    task automatic add(input logic bl, input logic bk,
                       input logic [3:0] m, input logic [3:0] t,
                       input logic [3:0] o, input logic [3:0] th,
                       input logic [3:0] ea, input logic [6:0] es,
                       input logic ed);
        add2(bl, bk, m, t, o, th, ea, es, ed, ea, es, ed);
    endtask

    task automatic scan_1534(input logic bk);
        add(0, bk, 1, 5, 3, 4, 4'b1110, S4, 1'b1);
        add(0, bk, 1, 5, 3, 4, 4'b1101, S3, 1'b0);
        add(0, bk, 1, 5, 3, 4, 4'b1011, S5, 1'b1);
        add(0, bk, 1, 5, 3, 4, 4'b0111, S1, 1'b1);
    endtask

    task automatic off_rows(input int n);
        for (int k = 0; k < n; k++)
            add(0, 1, 1, 5, 3, 4, AN_OFF, SEG_OFF, 1'b1);
    endtask

    task automatic check(input string name,
                         input logic [3:0] a, input logic [6:0] s,
                         input logic d, input logic [3:0] ea,
                         input logic [6:0] es, input logic ed);
        checks++;
        if ({a, s, d} !== {ea, es, ed}) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     name, a, s, d, ea, es, ed);
        end
    endtask

    task automatic check_both(input string name,
                              input logic [3:0] ea, input logic [6:0] es,
                              input logic ed);
        check({name, " lzb1"}, an, seg, dp, ea, es, ed);
        check({name, " lzb0"}, an0, seg0, dp0, ea, es, ed);
    endtask

    initial begin
        // scan0: snapshot still zero
        add(0, 0, 1, 2, 3, 4, 4'b1110, S0, 1'b1);
        add(0, 0, 1, 2, 3, 4, 4'b1101, S0, 1'b0);
        add(0, 0, 1, 2, 3, 4, 4'b1011, S0, 1'b1);
        add2(0, 0, 1, 2, 3, 4, AN_OFF, SEG_OFF, 1'b1, 4'b0111, S0, 1'b1);
        // scan1: 1,2,3,4 captured
        add(0, 0, 1, 2, 3, 4, 4'b1110, S4, 1'b1);
        add(0, 0, 1, 2, 3, 4, 4'b1101, S3, 1'b0);
        add(0, 0, 1, 2, 3, 4, 4'b1011, S2, 1'b1);
        add(0, 0, 1, 2, 3, 4, 4'b0111, S1, 1'b1);
        // scan2: tens changes 2->5 during idx1, still shows 2
        add(0, 0, 1, 2, 3, 4, 4'b1110, S4, 1'b1);
        add(0, 0, 1, 5, 3, 4, 4'b1101, S3, 1'b0);
        add(0, 0, 1, 5, 3, 4, 4'b1011, S2, 1'b1);
        add(0, 0, 1, 5, 3, 4, 4'b0111, S1, 1'b1);
        // scan3: shows 5; minutes=0 and tenths=C presented before capture
        add(0, 0, 1, 5, 3, 4, 4'b1110, S4, 1'b1);
        add(0, 0, 1, 5, 3, 4, 4'b1101, S3, 1'b0);
        add(0, 0, 1, 5, 3, 4, 4'b1011, S5, 1'b1);
        add(0, 0, 0, 5, 3, 4'hC, 4'b0111, S1, 1'b1);
        // scan4: dash on tenths, blanked zero minutes
        add(0, 0, 1, 5, 3, 4, 4'b1110, SD, 1'b1);
        add(0, 0, 1, 5, 3, 4, 4'b1101, S3, 1'b0);
        add(0, 0, 1, 5, 3, 4, 4'b1011, S5, 1'b1);
        add2(0, 0, 1, 5, 3, 4, AN_OFF, SEG_OFF, 1'b1, 4'b0111, S0, 1'b1);
        // scan5: Blank for the idx0 slot only
        add(1, 0, 1, 5, 3, 4, AN_OFF, SEG_OFF, 1'b1);
        add(0, 0, 1, 5, 3, 4, 4'b1101, S3, 1'b0);
        add(0, 0, 1, 5, 3, 4, 4'b1011, S5, 1'b1);
        add(0, 0, 1, 5, 3, 4, 4'b0111, S1, 1'b1);
        // scans 6..10: blink enabled, off-on-off in 2-scan halves
        off_rows(8);
        scan_1534(1'b1);
        scan_1534(1'b1);
        off_rows(4);
        // scan11 first half, blink disabled again
        add(0, 0, 1, 5, 3, 4, 4'b1110, S4, 1'b1);
        add(0, 0, 1, 5, 3, 4, 4'b1101, S3, 1'b0);

        reset = 1'b1;
        blank = 1'b0; blink_en = 1'b0;
        minutes = 4'd1; tens_s = 4'd2; ones_s = 4'd3; tenths_s = 4'd4;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_both($sformatf("reset cyc%0d", c), AN_OFF, SEG_OFF, 1'b1);
        end
        reset = 1'b0;

        foreach (vecs[i]) begin
            blank = vecs[i].blank; blink_en = vecs[i].blink;
            minutes = vecs[i].m; tens_s = vecs[i].t;
            ones_s = vecs[i].o; tenths_s = vecs[i].th;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                check($sformatf("row%0d cyc%0d lzb1", i, c),
                      an, seg, dp, vecs[i].an, vecs[i].seg, vecs[i].dp);
                check($sformatf("row%0d cyc%0d lzb0", i, c),
                      an0, seg0, dp0, vecs[i].an0, vecs[i].seg0, vecs[i].dp0);
            end
        end

        // mid-digit reset during the idx2 slot
        @(posedge clk); #1;
        check_both("pre-reset idx2 a", 4'b1011, S5, 1'b1);
        @(posedge clk); #1;
        check_both("pre-reset idx2 b", 4'b1011, S5, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_both("mid reset", AN_OFF, SEG_OFF, 1'b1);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check_both($sformatf("post-reset idx0 cyc%0d", c), 4'b1110, S0, 1'b1);
        end
        @(posedge clk); #1;
        check_both("post-reset idx1", 4'b1101, S0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
